// File: rtl/tc_step_counter.sv
// Step/direction counter with programmable limit, wrap/saturate/one-shot modes and lagged output.
// Optional macro TC_STEP_COUNTER_STICKY_EN adds clr_ovf input and ovf_sticky output.
module tc_step_counter #(
  parameter int BIT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [BIT_WIDTH-1:0] load_val,
  input  logic [BIT_WIDTH-1:0] step,
  input  logic                 dir,
  input  logic [BIT_WIDTH-1:0] limit,
  input  logic [1:0]           mode,
  input  logic                 start,
`ifdef TC_STEP_COUNTER_STICKY_EN
  input  logic                 clr_ovf,
  output logic                 ovf_sticky,
`endif
  output logic [BIT_WIDTH-1:0] out,
  output logic                 tc,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef struct packed {
    logic [BIT_WIDTH-1:0] val;
    logic                 tc;
    logic                 hit;
  } step_res_t;

  state_t               state;
  state_t               state_n;
  logic [BIT_WIDTH-1:0] value_p0;
  logic [BIT_WIDTH-1:0] value_n;
  logic                 tc_p0;
  logic                 tc_n;
  step_res_t            res;

  // hit flags an overflow/underflow; tc additionally requires a visible change when saturating
  function automatic step_res_t count_step(
    input logic [BIT_WIDTH-1:0] v,
    input logic [BIT_WIDTH-1:0] s,
    input logic [BIT_WIDTH-1:0] lim,
    input logic                 d,
    input logic                 sat
  );
    logic [BIT_WIDTH:0] sum;
    step_res_t          r;
    sum   = {1'b0, v} + {1'b0, s};
    r.val = d ? (v - s) : sum[BIT_WIDTH-1:0];
    r.tc  = 1'b0;
    r.hit = 1'b0;
    if (s == '0) begin
      r.val = v;
    end else if (!d && (sum > {1'b0, lim})) begin
      r.hit = 1'b1;
      r.val = sat ? lim : '0;
      r.tc  = sat ? (v != lim) : 1'b1;
    end else if (d && (s > v)) begin
      r.hit = 1'b1;
      r.val = sat ? '0 : lim;
      r.tc  = sat ? (v != '0) : 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    res     = count_step(value_p0, step, limit, dir, (mode == 2'b01) || (mode == 2'b10));
    value_n = value_p0;
    tc_n    = 1'b0;
    state_n = (mode == 2'b10) ? state : IDLE;
    if (load) begin
      value_n = load_val;
    end else if (mode == 2'b10) begin
      if (start) begin
        value_n = load_val;
        state_n = RUN;
      end else if ((state == RUN) && en) begin
        value_n = res.val;
        tc_n    = res.hit;
        if (res.hit) state_n = DONE;
      end
    end else if (en) begin
      value_n = res.val;
      tc_n    = res.tc;
    end
  end

  // stage p0: internal value, its tc and FSM state; stage p1: lagged out/tc
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_p0 <= '0;
      tc_p0    <= 1'b0;
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      out      <= '0;
      tc       <= 1'b0;
    end else begin
      value_p0 <= value_n;
      tc_p0    <= tc_n;
      state    <= state_n;
      busy     <= (state_n == RUN);
      done     <= (state_n == DONE);
      out      <= value_p0;
      tc       <= tc_p0;
    end
  end

`ifdef TC_STEP_COUNTER_STICKY_EN
  // sets on the same edge that raises tc; a simultaneous clear loses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else begin
      ovf_sticky <= tc_p0 | (ovf_sticky & ~clr_ovf);
    end
  end
`endif

endmodule
